// File: rtl/seq_det_pkg.sv
// Shared constants and types for the multiplexed 4-bit sequence detector.
package seq_det_pkg;

  // 4-bit window value as presented on the result port.
  typedef logic [3:0] hit_code_t;

  localparam hit_code_t PAT_A     = 4'b1001;
  localparam hit_code_t PAT_B     = 4'b1110;
  localparam hit_code_t CODE_NONE = 4'b0000;

  // True when a full 4-bit window equals one of the reported patterns.
  function automatic logic is_pattern(input hit_code_t w);
    return (w == PAT_A) || (w == PAT_B);
  endfunction

endpackage

// File: rtl/seq_det_rr_arb.sv
// Round-robin arbiter: grants the first eligible channel at or above rr_ptr
// (with wrap) and moves rr_ptr just past the winner on every grant.
module seq_det_rr_arb #(
  parameter int NCH  = 4,
  parameter int CH_W = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NCH-1:0]  eligible,
  input  logic            en,
  output logic [NCH-1:0]  grant,
  output logic [CH_W-1:0] gnt_idx,
  output logic            gnt_any
);

  logic [CH_W-1:0] rr_ptr;

  // Rotating priority search starting at rr_ptr; nothing is granted when en=0.
  always_comb begin
    int j;
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = 0;
    for (int i = 0; i < NCH; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NCH) j = j - NCH;
      if (en && !gnt_any && eligible[j]) begin
        gnt_any  = 1'b1;
        grant[j] = 1'b1;
        gnt_idx  = CH_W'(j);
      end
    end
  end

  // Pointer advances to the channel after the winner, only when a grant happens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (gnt_any) begin
      rr_ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CH_W'(1);
    end
  end

endmodule

// File: rtl/seq_det_mux_ctrl.sv
// Shares one 4-bit pattern matcher among NCH serial lanes. Each lane keeps its
// own 3-bit history, so detection is per lane and overlapping. Hits (1001 or
// 1110) go out on a single result port and bump a saturating per-lane counter.
//
// Handshakes: an input bit on lane c transfers on a rising edge where
// req_valid[c] & req_ready[c]; req_ready is a one-hot grant that depends only on
// valid/flush/result-port state, never on req_bit. A result transfers on an edge
// where hit_valid & hit_ready; while hit_valid=1 and hit_ready=0 the result
// fields hold and no lane is granted, so no bit is consumed that could overwrite
// an unaccepted hit.
module seq_det_mux_ctrl
  import seq_det_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CH_W  = $clog2(NCH),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_bit,
  input  logic [NCH-1:0]   req_flush,
  output logic [NCH-1:0]   req_ready,
  output logic             hit_valid,
  input  logic             hit_ready,
  output logic [CH_W-1:0]  hit_ch,
  output hit_code_t        hit_code,
  input  logic             clr_cnt,
  input  logic [CH_W-1:0]  cnt_sel,
  output logic [CNT_W-1:0] cnt_val
);

  logic [2:0]       hist [NCH];
  logic [1:0]       len  [NCH];
  logic [CNT_W-1:0] cnt  [NCH];

  logic [NCH-1:0]   grant;
  logic [CH_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             en;
  logic             gnt_bit;
  hit_code_t        window;
  logic             match;

  assign en        = !hit_valid || hit_ready;
  assign req_ready = grant;

  seq_det_rr_arb #(
    .NCH  (NCH),
    .CH_W (CH_W)
  ) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (req_valid & ~req_flush),
    .en       (en),
    .grant    (grant),
    .gnt_idx  (gnt_idx),
    .gnt_any  (gnt_any)
  );

  // The single shared matcher looks at the granted lane's history plus its new bit.
  assign gnt_bit = req_bit[gnt_idx];
  assign window  = {hist[gnt_idx], gnt_bit};
  assign match   = gnt_any && (len[gnt_idx] == 2'd3) && is_pattern(window);

  // Per-lane history shift; flush wins and a flushed lane is never granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        len[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (req_flush[i]) begin
          hist[i] <= '0;
          len[i]  <= '0;
        end else if (grant[i]) begin
          hist[i] <= {hist[i][1:0], req_bit[i]};
          if (len[i] != 2'd3) len[i] <= len[i] + 2'd1;
        end
      end
    end
  end

  // Result register: a new hit may replace one being accepted this same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_valid <= 1'b0;
      hit_ch    <= '0;
      hit_code  <= CODE_NONE;
    end else if (match) begin
      hit_valid <= 1'b1;
      hit_ch    <= gnt_idx;
      hit_code  <= window;
    end else if (hit_ready) begin
      hit_valid <= 1'b0;
    end
  end

  // Saturating hit counters; a clear in the same cycle as a hit wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (clr_cnt) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (match && (cnt[gnt_idx] != '1)) begin
      cnt[gnt_idx] <= cnt[gnt_idx] + CNT_W'(1);
    end
  end

  // Counter read port; out-of-range selects read as zero.
  always_comb begin
    cnt_val = '0;
    if (int'(cnt_sel) < NCH) cnt_val = cnt[cnt_sel];
  end

endmodule
